// File: rtl/k10_trace_checker_pkg.sv
// Shared types for the K10 lockstep trace checker: privilege levels, error causes,
// checker states and the expected-record layout (instr field only with K10_TRACE_CHK_INSTR_EN).
package k10_trace_checker_pkg;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_lvl_e;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_PC        = 3'd1,
        ERR_INSTR     = 3'd2,
        ERR_RD        = 3'd3,
        ERR_DATA      = 3'd4,
        ERR_MODE      = 3'd5,
        ERR_LEFTOVER  = 3'd6,
        ERR_UNDERFLOW = 3'd7
    } trk_err_e;

    typedef logic [1:0] chk_state_e;
    localparam chk_state_e CHK_RUN   = 2'd0;
    localparam chk_state_e CHK_DRAIN = 2'd1;
    localparam chk_state_e CHK_PASS  = 2'd2;
    localparam chk_state_e CHK_FAIL  = 2'd3;

    typedef struct packed {
        logic [31:0] pc;
`ifdef K10_TRACE_CHK_INSTR_EN
        logic [31:0] instr;
`endif
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        priv_lvl_e   mode;
    } trace_rec_t;

    // First differing field in priority order; ERR_NONE when the records agree.
    function automatic trk_err_e rec_compare(input trace_rec_t exp_rec, input trace_rec_t dut_rec);
        trk_err_e cause;
        if (exp_rec.pc != dut_rec.pc) begin
            cause = ERR_PC;
`ifdef K10_TRACE_CHK_INSTR_EN
        end else if (exp_rec.instr != dut_rec.instr) begin
            cause = ERR_INSTR;
`endif
        end else if (exp_rec.rd_addr != dut_rec.rd_addr) begin
            cause = ERR_RD;
        end else if (exp_rec.rd_data != dut_rec.rd_data) begin
            cause = ERR_DATA;
        end else if (exp_rec.mode != dut_rec.mode) begin
            cause = ERR_MODE;
        end else begin
            cause = ERR_NONE;
        end
        return cause;
    endfunction

endpackage

// File: rtl/k10_trace_checker_if.sv
// Expected-record stream and WB commit tap seen by the trace checker.
interface k10_trace_checker_if;
    import k10_trace_checker_pkg::*;

    logic        i_exp_valid;
    logic        o_exp_ready;
    logic [31:0] i_exp_pc;
    logic [31:0] i_exp_instr;
    logic [4:0]  i_exp_rd_addr;
    logic [31:0] i_exp_rd_data;
    priv_lvl_e   i_exp_mode;
    logic        i_exp_done;

    logic        i_valid;
    logic [31:0] i_pc;
    logic [31:0] i_instr;
    logic [4:0]  i_rd_addr;
    logic [31:0] i_rd_data;
    logic        i_rd_wr_en;
    priv_lvl_e   i_mode;
    logic        i_dut_done;

    modport slave (
        input  i_exp_valid, i_exp_pc, i_exp_instr, i_exp_rd_addr, i_exp_rd_data,
               i_exp_mode, i_exp_done,
        input  i_valid, i_pc, i_instr, i_rd_addr, i_rd_data, i_rd_wr_en, i_mode,
               i_dut_done,
        output o_exp_ready
    );

    modport master (
        output i_exp_valid, i_exp_pc, i_exp_instr, i_exp_rd_addr, i_exp_rd_data,
               i_exp_mode, i_exp_done,
        output i_valid, i_pc, i_instr, i_rd_addr, i_rd_data, i_rd_wr_en, i_mode,
               i_dut_done,
        input  o_exp_ready
    );

endinterface

// File: rtl/k10_trace_checker_fifo.sv
// Generic synchronous FIFO (type- and depth-parameterised) with full/empty/occupancy.
// DEPTH must be a power of two so the pointers wrap naturally.
module k10_trace_fifo #(
    parameter type         T     = logic [7:0],
    parameter int unsigned DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  T                           i_wdata,
    input  logic                       i_pop,
    output T                           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    T                mem_q [DEPTH];
    T                mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok_s;
    logic            pop_ok_s;

    assign o_full    = (count_q == CW'(DEPTH));
    assign o_empty   = (count_q == CW'(0));
    assign o_count   = count_q;
    assign o_rdata   = mem_q[rd_ptr_q];
    assign push_ok_s = i_push && !o_full;
    assign pop_ok_s  = i_pop && !o_empty;

    // Next pointers, occupancy and storage image.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = i_wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state; flushed by the synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= CW'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted as valid.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/k10_trace_checker.sv
// Lockstep commit checker: compares filtered WB commits against buffered expected records
// and latches the first divergence. Optional instruction compare: K10_TRACE_CHK_INSTR_EN.
module k10_trace_checker
    import k10_trace_checker_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    k10_trace_checker_if.slave   bus,
    output logic                 o_error,
    output trk_err_e             o_err_code,
    output logic [31:0]          o_err_pc,
    output logic [CNT_W-1:0]     o_match_cnt,
    output logic                 o_pass
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    trace_rec_t        exp_rec_s;
    trace_rec_t        dut_rec_s;
    trace_rec_t        head_rec_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CW-1:0]     fifo_count_s;
    logic [CW-1:0]     cnt_post_pop_s;
    logic [CW-1:0]     count_next_s;
    logic              fc_s;
    logic              active_s;
    logic              push_s;
    logic              pop_s;
    trk_err_e          cmp_cause_s;

    chk_state_e        state_q, state_d;
    trk_err_e          err_code_q, err_code_d;
    logic [31:0]       err_pc_q, err_pc_d;
    logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
    logic              exp_ready_q, exp_ready_d;
    logic              error_q, error_d;
    logic              pass_q, pass_d;

    // Pack the incoming expected record and the DUT commit into the common layout.
    always_comb begin
        exp_rec_s         = '0;
        dut_rec_s         = '0;
        exp_rec_s.pc      = bus.i_exp_pc;
        exp_rec_s.rd_addr = bus.i_exp_rd_addr;
        exp_rec_s.rd_data = bus.i_exp_rd_data;
        exp_rec_s.mode    = bus.i_exp_mode;
        dut_rec_s.pc      = bus.i_pc;
        dut_rec_s.rd_addr = bus.i_rd_addr;
        dut_rec_s.rd_data = bus.i_rd_data;
        dut_rec_s.mode    = bus.i_mode;
`ifdef K10_TRACE_CHK_INSTR_EN
        exp_rec_s.instr   = bus.i_exp_instr;
        dut_rec_s.instr   = bus.i_instr;
`endif
    end

`ifndef K10_TRACE_CHK_INSTR_EN
    logic unused_instr_s;
    assign unused_instr_s = ^{bus.i_exp_instr, bus.i_instr};
`endif

    // Same filter the trace writer applies: only real register writes are traced.
    assign fc_s     = bus.i_valid && bus.i_rd_wr_en && (bus.i_rd_addr != 5'd0);
    assign active_s = (state_q == CHK_RUN) || (state_q == CHK_DRAIN);
    assign push_s   = bus.i_exp_valid && exp_ready_q;

    assign cmp_cause_s    = fifo_empty_s ? ERR_UNDERFLOW : rec_compare(head_rec_s, dut_rec_s);
    assign pop_s          = active_s && fc_s && (cmp_cause_s == ERR_NONE);
    assign cnt_post_pop_s = fifo_count_s - CW'(pop_s);
    assign count_next_s   = fifo_count_s + CW'(push_s) - CW'(pop_s);

    k10_trace_fifo #(
        .T     (trace_rec_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push_s),
        .i_wdata (exp_rec_s),
        .i_pop   (pop_s),
        .o_rdata (head_rec_s),
        .o_full  (fifo_full_s),
        .o_empty (fifo_empty_s),
        .o_count (fifo_count_s)
    );

    // Checker FSM: a compare error outranks end-of-test in the same cycle.
    always_comb begin
        state_d     = state_q;
        err_code_d  = err_code_q;
        err_pc_d    = err_pc_q;
        match_cnt_d = match_cnt_q;
        if (active_s) begin
            if (fc_s && (cmp_cause_s != ERR_NONE)) begin
                state_d    = CHK_FAIL;
                err_code_d = cmp_cause_s;
                err_pc_d   = bus.i_pc;
            end else if (bus.i_dut_done) begin
                if (cnt_post_pop_s != CW'(0)) begin
                    state_d    = CHK_FAIL;
                    err_code_d = ERR_LEFTOVER;
                    err_pc_d   = 32'd0;
                end else if (state_q == CHK_DRAIN) begin
                    state_d = CHK_PASS;
                end else begin
                    state_d    = CHK_FAIL;
                    err_code_d = ERR_LEFTOVER;
                    err_pc_d   = 32'd0;
                end
            end else if ((state_q == CHK_RUN) && bus.i_exp_done) begin
                state_d = CHK_DRAIN;
            end else begin
                state_d = state_q;
            end
            if (pop_s && (match_cnt_q != {CNT_W{1'b1}})) begin
                match_cnt_d = match_cnt_q + CNT_W'(1);
            end else begin
                match_cnt_d = match_cnt_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Ready looks one cycle ahead so it never depends on the commit port combinationally.
    always_comb begin
        exp_ready_d = ((state_d == CHK_RUN) || (state_d == CHK_DRAIN)) &&
                      (count_next_s != CW'(DEPTH));
        error_d     = (state_d == CHK_FAIL);
        pass_d      = (state_d == CHK_PASS);
    end

    // Checker state and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= CHK_RUN;
            err_code_q  <= ERR_NONE;
            err_pc_q    <= 32'd0;
            match_cnt_q <= {CNT_W{1'b0}};
            exp_ready_q <= 1'b0;
            error_q     <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_code_q  <= err_code_d;
            err_pc_q    <= err_pc_d;
            match_cnt_q <= match_cnt_d;
            exp_ready_q <= exp_ready_d;
            error_q     <= error_d;
            pass_q      <= pass_d;
        end
    end

    logic unused_full_s;
    assign unused_full_s = fifo_full_s;

    assign bus.o_exp_ready = exp_ready_q;
    assign o_error         = error_q;
    assign o_err_code      = err_code_q;
    assign o_err_pc        = err_pc_q;
    assign o_match_cnt     = match_cnt_q;
    assign o_pass          = pass_q;

endmodule

// File: tb/tb_k10_trace_checker.sv
// Self-checking bench for k10_trace_checker: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_k10_trace_checker;
    import k10_trace_checker_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    k10_trace_checker_if bif ();

    logic              o_error;
    trk_err_e          o_err_code;
    logic [31:0]       o_err_pc;
    logic [CNT_W-1:0]  o_match_cnt;
    logic              o_pass;

    k10_trace_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bif),
        .o_error     (o_error),
        .o_err_code  (o_err_code),
        .o_err_pc    (o_err_pc),
        .o_match_cnt (o_match_cnt),
        .o_pass      (o_pass)
    );

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] data;
        priv_lvl_e   mode;
    } rec_t;

    // Reference model: 0=run 1=drain 2=pass 3=fail
    rec_t        m_q[$];
    int          m_state = 0;
    int          m_code = 0;
    logic [31:0] m_pc = 32'd0;
    longint      m_cnt = 0;
    bit          m_ready = 1'b0;

    function automatic int field_cause(rec_t e, rec_t d);
        if (e.pc != d.pc) return 1;
`ifdef K10_TRACE_CHK_INSTR_EN
        if (e.instr != d.instr) return 2;
`endif
        if (e.rd != d.rd) return 3;
        if (e.data != d.data) return 4;
        if (e.mode != d.mode) return 5;
        return 0;
    endfunction

    function automatic priv_lvl_e pick_mode();
        case ($urandom_range(0, 2))
            0:       return PRIV_U;
            1:       return PRIV_S;
            default: return PRIV_M;
        endcase
    endfunction

    task automatic model_step();
        rec_t e, d;
        bit   fc, pushed;
        int   cause;
        if (!rst_n) begin
            m_q.delete(); m_state = 0; m_code = 0; m_pc = 32'd0; m_cnt = 0; m_ready = 1'b0;
            return;
        end
        if (m_state >= 2) begin
            m_ready = 1'b0;
            return;
        end
        pushed = bif.i_exp_valid && m_ready;
        e.pc = bif.i_exp_pc; e.instr = bif.i_exp_instr; e.rd = bif.i_exp_rd_addr;
        e.data = bif.i_exp_rd_data; e.mode = bif.i_exp_mode;
        d.pc = bif.i_pc; d.instr = bif.i_instr; d.rd = bif.i_rd_addr;
        d.data = bif.i_rd_data; d.mode = bif.i_mode;
        fc = bif.i_valid && bif.i_rd_wr_en && (bif.i_rd_addr != 5'd0);
        cause = 0;
        if (fc) begin
            if (m_q.size() == 0) cause = 7;
            else begin
                cause = field_cause(m_q[0], d);
                if (cause == 0) begin
                    void'(m_q.pop_front());
                    if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                end
            end
        end
        if (cause != 0) begin
            m_state = 3; m_code = cause; m_pc = d.pc;
        end else if (bif.i_dut_done) begin
            if (m_q.size() != 0 || m_state == 0) begin
                m_state = 3; m_code = 6; m_pc = 32'd0;
            end else m_state = 2;
        end else if (m_state == 0 && bif.i_exp_done) m_state = 1;
        if (pushed) m_q.push_back(e);
        m_ready = (m_state < 2) && (m_q.size() < DEPTH);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bif.i_exp_valid = 1'b0; bif.i_exp_pc = 32'd0; bif.i_exp_instr = 32'd0;
        bif.i_exp_rd_addr = 5'd0; bif.i_exp_rd_data = 32'd0; bif.i_exp_mode = PRIV_M;
        bif.i_exp_done = 1'b0; bif.i_valid = 1'b0; bif.i_pc = 32'd0; bif.i_instr = 32'd0;
        bif.i_rd_addr = 5'd0; bif.i_rd_data = 32'd0; bif.i_rd_wr_en = 1'b0;
        bif.i_mode = PRIV_M; bif.i_dut_done = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0; cyc(); cyc();
        rst_n = 1'b1; cyc();
    endtask

    task automatic set_exp(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data,
                           input priv_lvl_e mode);
        bif.i_exp_pc = pc; bif.i_exp_rd_addr = rd; bif.i_exp_rd_data = data;
        bif.i_exp_mode = mode; bif.i_exp_instr = $urandom;
    endtask

    task automatic push_rec(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data,
                            input priv_lvl_e mode);
        bif.i_exp_valid = 1'b1;
        set_exp(pc, rd, data, mode);
        cyc();
        bif.i_exp_valid = 1'b0;
    endtask

    task automatic commit(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data,
                          input priv_lvl_e mode);
        bif.i_valid = 1'b1; bif.i_rd_wr_en = 1'b1; bif.i_pc = pc; bif.i_rd_addr = rd;
        bif.i_rd_data = data; bif.i_mode = mode; bif.i_instr = $urandom;
        cyc();
        bif.i_valid = 1'b0; bif.i_rd_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0; cyc(); cyc();
        n_cmp++; if (bif.o_exp_ready !== 1'b0) begin n_fail++; $display("FAIL reset.ready got %0b want 0", bif.o_exp_ready); end
        n_cmp++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL reset.error got %0b want 0", o_error); end
        n_cmp++; if (o_pass !== 1'b0) begin n_fail++; $display("FAIL reset.pass got %0b want 0", o_pass); end
        n_cmp++; if (o_match_cnt !== 32'd0) begin n_fail++; $display("FAIL reset.cnt got %0d want 0", o_match_cnt); end
        n_cmp++; if (o_err_code !== ERR_NONE || o_err_pc !== 32'd0) begin n_fail++; $display("FAIL reset.errfields got %0d/%h want 0/0", o_err_code, o_err_pc); end
        rst_n = 1'b1; cyc();
        n_cmp++; if (bif.o_exp_ready !== 1'b1) begin n_fail++; $display("FAIL reset.ready_after got %0b want 1", bif.o_exp_ready); end
    endtask

    task automatic test_pass_flow();
        do_reset();
        for (int i = 0; i < 3; i++) push_rec(32'h8000_0000 + 32'(4 * i), 5'd10, 32'(i + 1), PRIV_M);
        for (int i = 0; i < 3; i++) commit(32'h8000_0000 + 32'(4 * i), 5'd10, 32'(i + 1), PRIV_M);
        bif.i_exp_done = 1'b1; cyc();
        n_cmp++; if (o_pass !== 1'b0) begin n_fail++; $display("FAIL pass_flow.early_pass got %0b want 0", o_pass); end
        bif.i_dut_done = 1'b1; cyc(); bif.i_dut_done = 1'b0;
        n_cmp++; if (o_pass !== 1'b1) begin n_fail++; $display("FAIL pass_flow.pass got %0b want 1", o_pass); end
        n_cmp++; if (o_match_cnt !== 32'd3) begin n_fail++; $display("FAIL pass_flow.cnt got %0d want 3", o_match_cnt); end
        n_cmp++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL pass_flow.error got %0b want 0", o_error); end
        n_cmp++; if (bif.o_exp_ready !== 1'b0) begin n_fail++; $display("FAIL pass_flow.ready got %0b want 0", bif.o_exp_ready); end
    endtask

    task automatic test_data_mismatch();
        do_reset();
        push_rec(32'h8000_0010, 5'd10, 32'h5, PRIV_M);
        bif.i_valid = 1'b1; bif.i_rd_wr_en = 1'b1; bif.i_pc = 32'h8000_0010; bif.i_rd_addr = 5'd10;
        bif.i_rd_data = 32'h6; bif.i_mode = PRIV_M;
        n_cmp++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL data.pre_error got %0b want 0", o_error); end
        cyc(); bif.i_valid = 1'b0; bif.i_rd_wr_en = 1'b0;
        n_cmp++; if (o_error !== 1'b1) begin n_fail++; $display("FAIL data.error got %0b want 1", o_error); end
        n_cmp++; if (o_err_code !== ERR_DATA) begin n_fail++; $display("FAIL data.code got %0d want 4", o_err_code); end
        n_cmp++; if (o_err_pc !== 32'h8000_0010) begin n_fail++; $display("FAIL data.pc got %h want 80000010", o_err_pc); end
        commit(32'h8000_0044, 5'd3, 32'h9, PRIV_U);
        push_rec(32'h1, 5'd1, 32'h1, PRIV_U);
        n_cmp++; if (o_err_code !== ERR_DATA || o_err_pc !== 32'h8000_0010 || o_match_cnt !== 32'd0) begin
            n_fail++; $display("FAIL data.frozen got %0d/%h/%0d want 4/80000010/0", o_err_code, o_err_pc, o_match_cnt); end
        n_cmp++; if (bif.o_exp_ready !== 1'b0) begin n_fail++; $display("FAIL data.ready got %0b want 0", bif.o_exp_ready); end
    endtask

    task automatic test_filter_underflow();
        do_reset();
        commit(32'h8000_0100, 5'd0, 32'h1, PRIV_M);
        bif.i_valid = 1'b1; bif.i_rd_wr_en = 1'b0; bif.i_rd_addr = 5'd5; cyc();
        bif.i_valid = 1'b0; bif.i_rd_wr_en = 1'b1; cyc();
        bif.i_rd_wr_en = 1'b0;
        n_cmp++; if (o_error !== 1'b0 || o_match_cnt !== 32'd0) begin n_fail++; $display("FAIL filter.quiet got err=%0b cnt=%0d want 0/0", o_error, o_match_cnt); end
        commit(32'h8000_0100, 5'd5, 32'h1, PRIV_M);
        n_cmp++; if (o_err_code !== ERR_UNDERFLOW) begin n_fail++; $display("FAIL underflow.code got %0d want 7", o_err_code); end
        n_cmp++; if (o_err_pc !== 32'h8000_0100 || o_error !== 1'b1) begin n_fail++; $display("FAIL underflow.pc got %h err=%0b want 80000100/1", o_err_pc, o_error); end
    endtask

    task automatic test_full();
        int accepted;
        do_reset();
        accepted = 0;
        bif.i_exp_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_exp(32'h8000_1000 + 32'(4 * i), 5'd7, 32'(i), PRIV_S);
            if (bif.o_exp_ready === 1'b1) accepted++;
            cyc();
        end
        n_cmp++; if (accepted != DEPTH) begin n_fail++; $display("FAIL full.accepted got %0d want %0d", accepted, DEPTH); end
        n_cmp++; if (bif.o_exp_ready !== 1'b0) begin n_fail++; $display("FAIL full.ready got %0b want 0", bif.o_exp_ready); end
        commit(32'h8000_1000, 5'd7, 32'd0, PRIV_S);
        n_cmp++; if (bif.o_exp_ready !== 1'b1) begin n_fail++; $display("FAIL full.ready_back got %0b want 1", bif.o_exp_ready); end
        n_cmp++; if (o_match_cnt !== 32'd1 || o_error !== 1'b0) begin n_fail++; $display("FAIL full.cnt got %0d err=%0b want 1/0", o_match_cnt, o_error); end
        bif.i_exp_valid = 1'b0;
    endtask

    task automatic test_priority_leftover();
        do_reset();
        push_rec(32'h8000_0200, 5'd11, 32'hAB, PRIV_M);
        commit(32'h8000_0204, 5'd11, 32'hAB, PRIV_U);
        n_cmp++; if (o_err_code !== ERR_PC || o_err_pc !== 32'h8000_0204) begin n_fail++; $display("FAIL priority.code got %0d/%h want 1/80000204", o_err_code, o_err_pc); end
        do_reset();
        push_rec(32'h8000_0300, 5'd12, 32'h1, PRIV_M);
        push_rec(32'h8000_0304, 5'd12, 32'h2, PRIV_M);
        bif.i_exp_done = 1'b1; cyc();
        bif.i_dut_done = 1'b1; cyc(); bif.i_dut_done = 1'b0;
        n_cmp++; if (o_err_code !== ERR_LEFTOVER || o_err_pc !== 32'd0) begin n_fail++; $display("FAIL leftover.code got %0d/%h want 6/0", o_err_code, o_err_pc); end
        n_cmp++; if (o_error !== 1'b1 || o_pass !== 1'b0) begin n_fail++; $display("FAIL leftover.flags got err=%0b pass=%0b want 1/0", o_error, o_pass); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        for (int i = 0; i < 4; i++) push_rec(32'h8000_0400 + 32'(4 * i), 5'd9, 32'(i), PRIV_M);
        commit(32'h8000_0500, 5'd9, 32'd0, PRIV_M);
        n_cmp++; if (o_error !== 1'b1) begin n_fail++; $display("FAIL midrun.error got %0b want 1", o_error); end
        rst_n = 1'b0; bif.i_exp_done = 1'b0; cyc();
        n_cmp++; if (o_error !== 1'b0 || o_pass !== 1'b0 || o_err_code !== ERR_NONE || o_err_pc !== 32'd0 ||
                     o_match_cnt !== 32'd0 || bif.o_exp_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrun.reset got err=%0b pass=%0b code=%0d pc=%h cnt=%0d rdy=%0b want all 0",
                               o_error, o_pass, o_err_code, o_err_pc, o_match_cnt, bif.o_exp_ready); end
        rst_n = 1'b1; cyc();
        push_rec(32'h8000_0600, 5'd4, 32'h77, PRIV_U);
        commit(32'h8000_0600, 5'd4, 32'h77, PRIV_U);
        bif.i_exp_done = 1'b1; cyc();
        bif.i_dut_done = 1'b1; cyc(); bif.i_dut_done = 1'b0;
        n_cmp++; if (o_pass !== 1'b1 || o_match_cnt !== 32'd1) begin n_fail++; $display("FAIL midrun.session got pass=%0b cnt=%0d want 1/1", o_pass, o_match_cnt); end
    endtask

    task automatic test_random();
        rec_t h;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            idle();
            bif.i_exp_done = ((i % 500) >= 420);
            if ($urandom_range(0, 1) == 1) begin
                bif.i_exp_valid = 1'b1;
                set_exp($urandom & 32'hFFFF_FFFC, 5'($urandom_range(1, 31)), $urandom, pick_mode());
            end
            if (m_q.size() > 0 && $urandom_range(0, 99) < 45) begin
                h = m_q[0];
                bif.i_valid = 1'b1; bif.i_rd_wr_en = 1'b1; bif.i_pc = h.pc; bif.i_instr = h.instr;
                bif.i_rd_addr = h.rd; bif.i_rd_data = h.data; bif.i_mode = h.mode;
                if ($urandom_range(0, 99) < 3) begin
                    case ($urandom_range(0, 4))
                        0:       bif.i_pc = h.pc ^ 32'h4;
                        1:       bif.i_instr = h.instr ^ 32'h1;
                        2:       bif.i_rd_addr = (h.rd == 5'd31) ? 5'd30 : h.rd + 5'd1;
                        3:       bif.i_rd_data = h.data ^ 32'h1;
                        default: bif.i_mode = (h.mode == PRIV_M) ? PRIV_U : PRIV_M;
                    endcase
                end
            end else if ($urandom_range(0, 99) < 15) begin
                bif.i_valid = 1'($urandom_range(0, 1)); bif.i_pc = $urandom; bif.i_rd_data = $urandom;
                if ($urandom_range(0, 1) == 1) begin bif.i_rd_wr_en = 1'b1; bif.i_rd_addr = 5'd0; end
                else begin bif.i_rd_wr_en = 1'b0; bif.i_rd_addr = 5'($urandom_range(1, 31)); end
            end else if ($urandom_range(0, 199) == 0) begin
                bif.i_valid = 1'b1; bif.i_rd_wr_en = 1'b1; bif.i_rd_addr = 5'd1; bif.i_pc = $urandom;
            end
            if ((i % 500) == 499) begin bif.i_exp_valid = 1'b0; bif.i_dut_done = 1'b1; end
            cyc();
            n_cmp++;
            if (o_error !== (m_state == 3) || o_pass !== (m_state == 2) || o_err_code !== 3'(m_code) ||
                o_err_pc !== m_pc || o_match_cnt !== 32'(m_cnt) || bif.o_exp_ready !== m_ready) begin
                n_fail++;
                $display("FAIL random.cycle%0d got err=%0b pass=%0b code=%0d pc=%h cnt=%0d rdy=%0b want err=%0b pass=%0b code=%0d pc=%h cnt=%0d rdy=%0b",
                         i, o_error, o_pass, o_err_code, o_err_pc, o_match_cnt, bif.o_exp_ready,
                         (m_state == 3), (m_state == 2), m_code, m_pc, m_cnt, m_ready);
            end
            if (m_state >= 2) do_reset();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_pass_flow();
        test_data_mismatch();
        test_filter_underflow();
        test_full();
        test_priority_leftover();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
